// File: rtl/pool_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_pkg : shared types for the max-pool feeder          rev 1.0
// ---------------------------------------------------------------------------
package pool_pkg;

    localparam int NUM_CH      = 3;
    localparam int DATA_W_DFLT = 16;
    localparam int TAG_W_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROW_A = 2'd1,
        ST_ROW_B = 2'd2,
        ST_FLUSH = 2'd3
    } feeder_state_t;

    typedef struct packed {
        logic                  row_b;
        logic [TAG_W_BITS-1:0] w;
    } pool_tag_t;

    // Index width that stays legal when only one entry exists.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_colbuf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_colbuf : first-row partial maxima, one write / one read   rev 1.0
// ---------------------------------------------------------------------------
module pool_colbuf
    import pool_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = clog2_min1(DEPTH)
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic                          i_wr_en,
    input  logic [ADDR_W-1:0]             i_wr_addr,
    input  logic [NUM_CH:1][DATA_W-1:0]   i_wr_data,
    input  logic [ADDR_W-1:0]             i_rd_addr,
    output logic [NUM_CH:1][DATA_W-1:0]   o_rd_data
);

    logic [NUM_CH:1][DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_wr_en && (int'(i_wr_addr) < DEPTH)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_comb begin
        o_rd_data = '0;
        if (int'(i_rd_addr) < DEPTH) o_rd_data = r_mem[i_rd_addr];
    end

endmodule
`default_nettype wire

// File: rtl/pool_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pool_feeder : raster pixels -> 2x2/2 max-pool PE driver        rev 1.0
// Optional stall_cnt output: define POOL_FEEDER_STALL_CNT_EN
// ---------------------------------------------------------------------------
module pool_feeder
    import pool_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int PE_LAT = 1
) (
    input  logic                                clk,
    input  logic                                n_reset,
    input  logic                                frame_start,
    input  logic [NUM_CH:1]                     ch_en,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_CH:1][DATA_W-1:0]         in_data,
    output logic [NUM_CH:1][DATA_W-1:0]         input_feature,
    output logic [NUM_CH:1][DATA_W-1:0]         last_max,
    output logic [NUM_CH:1]                     enable_pool,
    output logic                                start,
    input  logic [NUM_CH:1][DATA_W-1:0]         pool_out,
    output logic                                res_valid,
    output logic [NUM_CH:1][DATA_W-1:0]         res_data,
    output logic [clog2_min1(IMG_W/2)-1:0]      res_col,
    output logic [clog2_min1(IMG_H/2)-1:0]      res_row,
    output logic                                frame_done
`ifdef POOL_FEEDER_STALL_CNT_EN
    ,
    output logic [31:0]                         stall_cnt
`endif
);

    localparam int COL_W  = clog2_min1(IMG_W/2);
    localparam int ROW_W  = clog2_min1(IMG_H/2);
    localparam int CNT_CW = clog2_min1(IMG_W);
    localparam int CNT_RW = clog2_min1(IMG_H);

    feeder_state_t            r_state;
    logic [CNT_CW-1:0]        r_col;
    logic [CNT_RW-1:0]        r_row;
    logic [ROW_W-1:0]         r_res_row;
    logic [PE_LAT-1:0]        r_dl_vld;
    pool_tag_t                r_dl_tag [PE_LAT];

    logic                     w_accept, w_odd, w_last_col, w_last_row;
    logic                     w_exit, w_bypass;
    logic [COL_W-1:0]         w_win, w_exit_win;
    pool_tag_t                w_exit_tag;
    logic [NUM_CH:1][DATA_W-1:0] w_cb_rd;

    assign in_ready   = (r_state == ST_ROW_A) || (r_state == ST_ROW_B);
    assign w_accept   = in_valid && in_ready;
    assign w_odd      = r_col[0];
    assign w_win      = COL_W'(r_col >> 1);
    assign w_last_col = (r_col == CNT_CW'(IMG_W-1));
    assign w_last_row = (r_row == CNT_RW'(IMG_H-1));
    assign w_exit     = r_dl_vld[PE_LAT-1];
    assign w_exit_tag = r_dl_tag[PE_LAT-1];
    assign w_exit_win = COL_W'(w_exit_tag.w);
    // A first-row result retiring in the same cycle its window is read back.
    assign w_bypass   = w_exit && !w_exit_tag.row_b && (w_exit_win == w_win);

    assign input_feature = w_accept ? in_data : '0;
    assign enable_pool   = w_accept ? ch_en : '0;
    assign start         = w_accept && (r_state == ST_ROW_A) && !w_odd;

    always_comb begin
        last_max = '0;
        if (w_accept) begin
            if (w_odd)                        last_max = pool_out;
            else if (r_state == ST_ROW_B)     last_max = w_bypass ? pool_out : w_cb_rd;
        end
    end

    assign res_valid  = w_exit && w_exit_tag.row_b;
    assign res_col    = res_valid ? w_exit_win : '0;
    assign res_row    = res_valid ? r_res_row : '0;
    assign frame_done = (r_state == ST_FLUSH) && (r_dl_vld == '0);

    always_comb begin
        res_data = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (res_valid && ch_en[i]) res_data[i] = pool_out[i];
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (frame_start) begin
                    r_state <= ST_ROW_A;
                    r_col   <= '0;
                    r_row   <= '0;
                end
                ST_ROW_A, ST_ROW_B: if (w_accept) begin
                    if (w_last_col) begin
                        r_col <= '0;
                        if (r_state == ST_ROW_A) begin
                            r_state <= ST_ROW_B;
                            r_row   <= r_row + CNT_RW'(1);
                        end else if (w_last_row) begin
                            r_state <= ST_FLUSH;
                            r_row   <= '0;
                        end else begin
                            r_state <= ST_ROW_A;
                            r_row   <= r_row + CNT_RW'(1);
                        end
                    end else begin
                        r_col <= r_col + CNT_CW'(1);
                    end
                end
                ST_FLUSH: if (r_dl_vld == '0) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // Free-running tag pipe, aligned with the PE output latency.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_dl_vld <= '0;
            for (int i = 0; i < PE_LAT; i++) r_dl_tag[i] <= '0;
        end else begin
            r_dl_vld[0] <= w_accept && w_odd;
            r_dl_tag[0] <= '{row_b: (r_state == ST_ROW_B), w: TAG_W_BITS'(w_win)};
            for (int i = 1; i < PE_LAT; i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
                r_dl_tag[i] <= r_dl_tag[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_res_row <= '0;
        end else if ((r_state == ST_IDLE) && frame_start) begin
            r_res_row <= '0;
        end else if (res_valid && (w_exit_win == COL_W'(IMG_W/2-1))) begin
            r_res_row <= (r_res_row == ROW_W'(IMG_H/2-1)) ? '0 : r_res_row + ROW_W'(1);
        end
    end

`ifdef POOL_FEEDER_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_IDLE) && frame_start) begin
            r_stall_cnt <= '0;
        end else if (in_ready && !in_valid && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end
    assign stall_cnt = r_stall_cnt;
`endif

    pool_colbuf #(
        .DEPTH  (IMG_W/2),
        .DATA_W (DATA_W),
        .ADDR_W (COL_W)
    ) u_colbuf (
        .clk       (clk),
        .n_reset   (n_reset),
        .i_wr_en   (w_exit && !w_exit_tag.row_b),
        .i_wr_addr (w_exit_win),
        .i_wr_data (pool_out),
        .i_rd_addr (w_win),
        .o_rd_data (w_cb_rd)
    );

endmodule
`default_nettype wire

// File: tb/tb_pool_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pool_feeder : two feeders (PE_LAT 1 and 3) with behavioural max PEs
// ---------------------------------------------------------------------------
module tb_pool_feeder;

    localparam int DW = 16;
    localparam int IW = 4;
    localparam int IH = 2;
    localparam int RW = 3*DW + 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 n_reset, frame_start, in_valid;
    logic [3:1]           ch_en;
    logic [3:1][DW-1:0]   in_data;

    logic                 rdy [2];
    logic [3:1][DW-1:0]   inf [2];
    logic [3:1][DW-1:0]   lmx [2];
    logic [3:1][DW-1:0]   rd  [2];
    wire  [3:1][DW-1:0]   po  [2];
    logic [3:1]           en  [2];
    logic                 st [2], rv [2], fd [2];
    logic [0:0]           rc [2], rr [2];
`ifdef POOL_FEEDER_STALL_CNT_EN
    logic [31:0]          scnt [2];
`endif

    int n_tests = 0, n_fail = 0, cyc = 0;
    int pix [3:1][IH][IW];
    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] got_q [2][$];
    int last_res [2], first_res [2], fd_cyc [2], fd_cnt [2];
    int gap_viol = 0, mask_viol = 0;

    pool_feeder #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .PE_LAT(1)) u_dut1 (
        .clk(clk), .n_reset(n_reset), .frame_start(frame_start), .ch_en(ch_en),
        .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .input_feature(inf[0]), .last_max(lmx[0]), .enable_pool(en[0]), .start(st[0]),
        .pool_out(po[0]), .res_valid(rv[0]), .res_data(rd[0]), .res_col(rc[0]),
        .res_row(rr[0]), .frame_done(fd[0])
`ifdef POOL_FEEDER_STALL_CNT_EN
        , .stall_cnt(scnt[0])
`endif
    );

    pool_feeder #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .PE_LAT(3)) u_dut3 (
        .clk(clk), .n_reset(n_reset), .frame_start(frame_start), .ch_en(ch_en),
        .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
        .input_feature(inf[1]), .last_max(lmx[1]), .enable_pool(en[1]), .start(st[1]),
        .pool_out(po[1]), .res_valid(rv[1]), .res_data(rd[1]), .res_col(rc[1]),
        .res_row(rr[1]), .frame_done(fd[1])
`ifdef POOL_FEEDER_STALL_CNT_EN
        , .stall_cnt(scnt[1])
`endif
    );

    // Max PE: result appears L cycles after enable and is held afterwards.
    for (genvar k = 0; k < 2; k++) begin : g_pe
        localparam int L = (k == 0) ? 1 : 3;
        for (genvar c = 1; c <= 3; c++) begin : g_ch
            logic [L-1:0]         v;
            logic signed [DW-1:0] m [L];
            logic signed [DW-1:0] hold, a, b, nm;
            assign a  = inf[k][c];
            assign b  = lmx[k][c];
            assign nm = (st[k] || a > b) ? a : b;
            always @(posedge clk or negedge n_reset) begin
                if (!n_reset) begin
                    v    <= '0;
                    hold <= '0;
                    for (int i = 0; i < L; i++) m[i] <= '0;
                end else begin
                    v[0] <= en[k][c];
                    m[0] <= nm;
                    for (int i = 1; i < L; i++) begin
                        v[i] <= v[i-1];
                        m[i] <= m[i-1];
                    end
                    if (v[L-1]) hold <= m[L-1];
                end
            end
            assign po[k][c] = v[L-1] ? m[L-1] : hold;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rv[k]) begin
                got_q[k].push_back({8'(rr[k]), 8'(rc[k]), rd[k]});
                if (got_q[k].size() == 1) first_res[k] = cyc;
                last_res[k] = cyc;
            end
            if (fd[k]) begin
                fd_cyc[k] = cyc;
                fd_cnt[k]++;
            end
            if (en[k] != 3'b000 && !in_valid) gap_viol++;
            if ((en[k] & ~ch_en) != 3'b000) mask_viol++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic rand_pix();
        logic [15:0] u;
        for (int ch = 1; ch <= 3; ch++)
            for (int r = 0; r < IH; r++)
                for (int c = 0; c < IW; c++) begin
                    u = 16'($urandom) | 16'h0001;
                    pix[ch][r][c] = int'($signed(u));
                end
    endtask

    // Reference: maximum of each 2x2 window, zero on disabled channels.
    task automatic build_expected(input logic [3:1] mask);
        logic [3:1][DW-1:0] d;
        int mx;
        exp_q.delete();
        for (int wr = 0; wr < IH/2; wr++)
            for (int wc = 0; wc < IW/2; wc++) begin
                for (int ch = 1; ch <= 3; ch++) begin
                    mx = pix[ch][2*wr][2*wc];
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++)
                            if (pix[ch][2*wr+dr][2*wc+dc] > mx) mx = pix[ch][2*wr+dr][2*wc+dc];
                    d[ch] = mask[ch] ? DW'(mx) : '0;
                end
                exp_q.push_back({8'(wr), 8'(wc), d});
            end
    endtask

    task automatic run_frame(input int gap, input bit mid_fs, input int stop_after);
        int f0, f1, t, idx;
        f0 = fd_cnt[0];
        f1 = fd_cnt[1];
        idx = 0;
        got_q[0].delete();
        got_q[1].delete();
        @(posedge clk); #2 frame_start = 1'b1;
        @(posedge clk); #2 frame_start = 1'b0;
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                in_valid = 1'b1;
                for (int ch = 1; ch <= 3; ch++) in_data[ch] = DW'(pix[ch][r][c]);
                t = 0;
                while (!rdy[0] && t < 50) begin
                    @(posedge clk); #2;
                    t++;
                end
                if (t == 50) begin
                    n_tests++; n_fail++;
                    $display("FAIL ready_timeout: in_ready stayed 0, required 1");
                    in_valid = 1'b0;
                    return;
                end
                @(posedge clk); #2;
                in_valid    = 1'b0;
                frame_start = 1'b0;
                idx++;
                if (idx == stop_after) return;
                if (mid_fs && idx == 5) frame_start = 1'b1;
                repeat (gap) begin
                    @(posedge clk); #2;
                    frame_start = 1'b0;
                end
            end
        t = 0;
        while ((fd_cnt[0] == f0 || fd_cnt[1] == f1) && t < 200) begin
            @(posedge clk); #2;
            t++;
        end
        n_tests++;
        if (t == 200) begin
            n_fail++;
            $display("FAIL frame_done_timeout: pulses seen %0d/%0d, required 1/1",
                     fd_cnt[0] - f0, fd_cnt[1] - f1);
        end
    endtask

    task automatic test_reset();
        n_reset  = 1'b0;
        in_valid = 1'b1;
        in_data  = {16'h1234, 16'h5678, 16'h9abc};
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({rdy[k], inf[k], lmx[k], en[k], st[k], rv[k], rd[k], rc[k], rr[k], fd[k]} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got ready=%b en=%b feat=%h, required all 0",
                         k, rdy[k], en[k], inf[k]);
            end
        end
        repeat (3) @(posedge clk);
        #2 n_reset = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_directed();
        logic [RW-1:0] g;
        int row0 [4] = '{1, 5, 2, 3};
        int row1 [4] = '{4, 0, 7, -8};
        rand_pix();
        for (int c = 0; c < IW; c++) begin
            pix[1][0][c] = row0[c];
            pix[1][1][c] = row1[c];
        end
        ch_en = 3'b111;
        build_expected(ch_en);
        run_frame(0, 1'b0, 0);
        n_tests++;
        if (got_q[0].size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL directed_count: got %0d required %0d", got_q[0].size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (got_q[0][i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL directed_res[%0d]: got %h required %h", i, got_q[0][i], exp_q[i]);
                end
            end
            g = got_q[0][0];
            n_tests++;
            if (g[DW-1:0] !== 16'd5) begin
                n_fail++;
                $display("FAIL directed_ch1_w0: got %0d required 5", $signed(g[DW-1:0]));
            end
            g = got_q[0][1];
            n_tests++;
            if (g[DW-1:0] !== 16'd7) begin
                n_fail++;
                $display("FAIL directed_ch1_w1: got %0d required 7", $signed(g[DW-1:0]));
            end
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (fd_cyc[k] !== last_res[k] + 1) begin
                n_fail++;
                $display("FAIL frame_done_timing[%0d]: got cycle %0d required %0d",
                         k, fd_cyc[k], last_res[k] + 1);
            end
        end
    endtask

    task automatic test_gaps();
        gap_viol = 0;
        build_expected(ch_en);
        run_frame(3, 1'b0, 0);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (got_q[k].size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL gaps_count[%0d]: got %0d required %0d", k, got_q[k].size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_tests++;
                    if (got_q[k][i] !== exp_q[i]) begin
                        n_fail++;
                        $display("FAIL gaps_res[%0d][%0d]: got %h required %h", k, i, got_q[k][i], exp_q[i]);
                    end
                end
            end
        end
        n_tests++;
        if (gap_viol !== 0) begin
            n_fail++;
            $display("FAIL gaps_enable: got %0d enable cycles without valid, required 0", gap_viol);
        end
        n_tests++;
        if (first_res[1] !== first_res[0] + 2 || last_res[1] !== last_res[0] + 2) begin
            n_fail++;
            $display("FAIL lat3_delay: got first/last %0d/%0d required %0d/%0d",
                     first_res[1], last_res[1], first_res[0] + 2, last_res[0] + 2);
        end
    endtask

    task automatic test_mask();
        logic [RW-1:0] g;
        mask_viol = 0;
        rand_pix();
        ch_en = 3'b101;
        build_expected(ch_en);
        run_frame(0, 1'b0, 0);
        n_tests++;
        if (mask_viol !== 0) begin
            n_fail++;
            $display("FAIL mask_enable: got %0d masked enables, required 0", mask_viol);
        end
        n_tests++;
        if (got_q[0].size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL mask_count: got %0d required %0d", got_q[0].size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                g = got_q[0][i];
                n_tests++;
                if (g !== exp_q[i] || g[2*DW-1:DW] !== '0) begin
                    n_fail++;
                    $display("FAIL mask_res[%0d]: got %h required %h", i, g, exp_q[i]);
                end
            end
        end
        ch_en = 3'b111;
    endtask

    task automatic test_extremes();
        logic [RW-1:0] g;
        for (int ch = 1; ch <= 3; ch++)
            for (int r = 0; r < IH; r++)
                for (int c = 0; c < IW; c++) pix[ch][r][c] = -32768;
        for (int ch = 1; ch <= 3; ch++) pix[ch][1][3] = 32767;
        build_expected(ch_en);
        run_frame(0, 1'b0, 0);
        n_tests++;
        if (got_q[0].size() != 2) begin
            n_fail++;
            $display("FAIL extreme_count: got %0d required 2", got_q[0].size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if (got_q[0][i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL extreme_res[%0d]: got %h required %h", i, got_q[0][i], exp_q[i]);
                end
            end
            g = got_q[0][0];
            n_tests++;
            if (g[DW-1:0] !== 16'h8000) begin
                n_fail++;
                $display("FAIL extreme_w0: got %h required 8000", g[DW-1:0]);
            end
            g = got_q[0][1];
            n_tests++;
            if (g[DW-1:0] !== 16'h7fff) begin
                n_fail++;
                $display("FAIL extreme_w1: got %h required 7fff", g[DW-1:0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        rand_pix();
        run_frame(0, 1'b0, 3);
        in_valid = 1'b1;
        in_data  = {16'h7777, 16'h5555, 16'h3333};
        n_reset  = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({rdy[k], inf[k], lmx[k], en[k], st[k], rv[k], rd[k], rc[k], rr[k], fd[k]} !== '0) begin
                n_fail++;
                $display("FAIL midreset_outputs[%0d]: got ready=%b en=%b feat=%h, required all 0",
                         k, rdy[k], en[k], inf[k]);
            end
        end
        repeat (2) @(posedge clk);
        #2 n_reset = 1'b1;
        in_valid = 1'b0;
        rand_pix();
        build_expected(ch_en);
        run_frame(0, 1'b0, 0);
        n_tests++;
        if (got_q[0].size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d required %0d", got_q[0].size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (got_q[0][i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL midreset_res[%0d]: got %h required %h", i, got_q[0][i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_midframe_start();
        rand_pix();
        build_expected(ch_en);
        run_frame(2, 1'b1, 0);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (got_q[k].size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL midfs_count[%0d]: got %0d required %0d", k, got_q[k].size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_tests++;
                    if (got_q[k][i] !== exp_q[i]) begin
                        n_fail++;
                        $display("FAIL midfs_res[%0d][%0d]: got %h required %h", k, i, got_q[k][i], exp_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        n_reset     = 1'b0;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        ch_en       = 3'b111;
        in_data     = '0;
        for (int k = 0; k < 2; k++) begin
            fd_cnt[k]    = 0;
            fd_cyc[k]    = 0;
            last_res[k]  = 0;
            first_res[k] = 0;
        end
        test_reset();
        test_directed();
        test_gaps();
        test_mask();
        test_extremes();
        test_reset_mid();
        test_midframe_start();
        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
